// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-fed UART transmitter with runtime baud divisor, parity and stop-bit selection
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   baud_div                  bit period = baud_div+1 cycles (minimum 4)
//   parity_mode, stop_bits    00 none / 01 even / 10 odd / 11 none; 0 one stop, 1 two stops
//   tx_data, tx_valid, tx_ready, tx_level   input FIFO push port and occupancy
//   tx_busy, tx_done, txd     activity flag, end-of-frame pulse, serial line (idle high)
module uart_tx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIV_WIDTH-1:0]               baud_div,
  input  logic [1:0]                         parity_mode,
  input  logic                               stop_bits,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    tx_level,
  output logic                               tx_busy,
  output logic                               tx_done,
  output logic                               txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int IW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t r_state, w_next;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [DATA_BITS-1:0] r_data;
  logic [DIV_WIDTH-1:0] r_div, r_cnt, w_div;
  logic [1:0] r_par;
  logic r_stop2, r_txd, r_done;
  logic [IW-1:0] r_idx;
  logic w_push, w_pop, w_empty, w_expire, w_last, w_par_en, w_txd;
  assign tx_level = LW'(r_wptr - r_rptr);
  assign w_empty  = r_wptr == r_rptr;
  // ready depends only on state and rst, never on tx_valid
  assign tx_ready = ~rst & (tx_level != LW'(FIFO_DEPTH));
  assign w_push   = tx_valid & tx_ready;
  assign w_div    = baud_div < DIV_WIDTH'(3) ? DIV_WIDTH'(3) : baud_div;
  assign w_expire = r_cnt == '0;
  assign w_par_en = r_par == 2'b01 || r_par == 2'b10;
  assign tx_busy  = r_state != IDLE || !w_empty;
  assign tx_done  = r_done;
  assign txd      = r_txd;
  // odd parity is even parity inverted, and bit 1 of the mode marks odd
  assign w_txd = r_state == START  ? 1'b0 :
                 r_state == DATA   ? r_data[r_idx] :
                 r_state == PARITY ? (^r_data) ^ r_par[1] : 1'b1;
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE:   if (!w_empty) begin w_next = START; w_pop = 1'b1; end
      START:  if (w_expire) w_next = DATA;
      DATA:   if (w_expire && r_idx == IW'(DATA_BITS-1)) w_next = w_par_en ? PARITY : STOP1;
      PARITY: if (w_expire) w_next = STOP1;
      STOP1:  if (w_expire) begin if (r_stop2) w_next = STOP2; else w_last = 1'b1; end
      STOP2:  if (w_expire) w_last = 1'b1;
      default: w_next = IDLE;
    endcase
    // end of the final stop bit: chain straight into the next start bit when data waits
    if (w_last) begin
      w_next = w_empty ? IDLE : START;
      w_pop  = !w_empty;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_txd   <= w_txd;
      r_done  <= w_last;
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= tx_data;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_data  <= r_mem[r_rptr[AW-1:0]];
        r_div   <= w_div;
        r_par   <= parity_mode;
        r_stop2 <= stop_bits;
        r_cnt   <= w_div;
        r_idx   <= '0;
      end else if (r_state != IDLE) begin
        r_cnt <= w_expire ? r_div : r_cnt - 1'b1;
        if (r_state == DATA && w_expire) r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed vector bench for uart_tx_engine (8-bit and 7-bit builds)
module tb_uart_tx_engine;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] baud_div = 16'd3;
  logic [1:0] parity_mode = 2'd0;
  logic stop_bits = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0, tx_valid7 = 1'b0;
  logic tx_ready, tx_busy, tx_done, txd;
  logic tx_ready7, tx_busy7, tx_done7, txd7;
  logic [4:0] tx_level, tx_level7;
  int n_cmp = 0, n_bad = 0;

  uart_tx_engine u8 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_level(tx_level),
    .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd));

  uart_tx_engine #(.DATA_BITS(7)) u7 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .tx_data(tx_data[6:0]), .tx_valid(tx_valid7), .tx_ready(tx_ready7), .tx_level(tx_level7),
    .tx_busy(tx_busy7), .tx_done(tx_done7), .txd(txd7));

  typedef struct {
    logic [15:0] div;
    logic [1:0]  par;
    logic        stop2;
    logic        sel;
    logic [7:0]  data;
    logic [11:0] bits;
    int          n;
    int          p;
  } vec_t;
  vec_t vt[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_valid7 = 1'b0;
    @(negedge clk);
    chk("rst_ready", tx_ready, 0);
    chk("rst_txd", txd, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", tx_ready, 1);
    chk("post_rst_level", tx_level, 0);
    chk("post_rst_busy", tx_busy, 0);
    chk("post_rst_done", tx_done, 0);
    chk("post_rst_txd7", txd7, 1);
  endtask

  task automatic push(input logic [7:0] d, input logic sel, output int w);
    tx_data = d;
    w = 0;
    if (sel) tx_valid7 = 1'b1; else tx_valid = 1'b1;
    while (!(sel ? tx_ready7 : tx_ready) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: tx_ready never rose for data %0h", d);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_valid7 = 1'b0;
  endtask

  task automatic check_frame(input logic [11:0] bits, input int n, input int p, input logic sel, input string name);
    for (int c = 0; c < n * p; c++) begin
      @(negedge clk);
      chk({name, "_txd"}, sel ? txd7 : txd, bits[c / p]);
      chk({name, "_done"}, sel ? tx_done7 : tx_done, c == n * p - 1);
    end
  endtask

  task automatic idle_check(input logic sel, input string name);
    @(negedge clk);
    chk({name, "_idle_txd"}, sel ? txd7 : txd, 1);
    chk({name, "_idle_done"}, sel ? tx_done7 : tx_done, 0);
    chk({name, "_idle_busy"}, sel ? tx_busy7 : tx_busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [11:0] bits, input int n, input int p,
                           input logic sel, input string name);
    int w;
    push(d, sel, w);
    chk({name, "_accept_wait"}, w, 0);
    chk({name, "_level_at_accept"}, sel ? tx_level7 : tx_level, 1);
    @(posedge clk);
    #1;
    chk({name, "_txd_before_start"}, sel ? txd7 : txd, 1);
    chk({name, "_level_after_pop"}, sel ? tx_level7 : tx_level, 0);
    chk({name, "_busy"}, sel ? tx_busy7 : tx_busy, 1);
    @(posedge clk);
    check_frame(bits, n, p, sel, name);
    idle_check(sel, name);
  endtask

  initial begin
    int w;
    logic [7:0] fb[18];
    vt[0] = '{16'd3, 2'd0, 1'b0, 1'b0, 8'h55, 12'h2AA, 10, 4};
    vt[1] = '{16'd3, 2'd1, 1'b1, 1'b1, 8'h03, 12'h606, 11, 4};
    vt[2] = '{16'd3, 2'd2, 1'b0, 1'b0, 8'h00, 12'h600, 11, 4};
    vt[3] = '{16'd3, 2'd2, 1'b0, 1'b0, 8'hFF, 12'h7FE, 11, 4};
    vt[4] = '{16'd0, 2'd0, 1'b0, 1'b0, 8'hA3, 12'h346, 10, 4};
    vt[5] = '{16'd5, 2'd1, 1'b1, 1'b0, 8'hA3, 12'hD46, 12, 6};
    vt[6] = '{16'd1, 2'd3, 1'b0, 1'b0, 8'h55, 12'h2AA, 10, 4};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      baud_div = vt[i].div;
      parity_mode = vt[i].par;
      stop_bits = vt[i].stop2;
      run_frame(vt[i].data, vt[i].bits, vt[i].n, vt[i].p, vt[i].sel, $sformatf("vec%0d", i));
    end

    // reset during data bit 3 with a second byte queued
    do_reset();
    baud_div = 16'd3;
    parity_mode = 2'd0;
    stop_bits = 1'b0;
    push(8'h55, 1'b0, w);
    push(8'h11, 1'b0, w);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_txd", txd, 1);
    chk("midrst_level", tx_level, 0);
    chk("midrst_done", tx_done, 0);
    chk("midrst_busy", tx_busy, 0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk("midrst_quiet_txd", txd, 1);
      chk("midrst_quiet_done", tx_done, 0);
    end
    run_frame(8'hA3, 12'h346, 10, 4, 1'b0, "after_rst");

    // divisor change mid-frame applies only to the following frame
    do_reset();
    baud_div = 16'd3;
    push(8'h55, 1'b0, w);
    push(8'h0F, 1'b0, w);
    chk("bd_txd_before_start", txd, 1);
    @(posedge clk);
    fork
      check_frame(12'h2AA, 10, 4, 1'b0, "bd_a");
      begin
        repeat (8) @(posedge clk);
        #1 baud_div = 16'd7;
      end
    join
    check_frame(12'h21E, 10, 8, 1'b0, "bd_b");
    idle_check(1'b0, "bd");

    // fill the FIFO behind an active frame, hold off one more write, stream all back to back
    do_reset();
    baud_div = 16'd3;
    for (int i = 0; i < 18; i++) fb[i] = 8'(i * 37 + 5);
    push(fb[0], 1'b0, w);
    fork
      begin
        for (int i = 1; i < 17; i++) begin
          push(fb[i], 1'b0, w);
          chk("fill_wait", w, 0);
        end
        chk("full_level", tx_level, 16);
        chk("full_ready", tx_ready, 0);
        chk("full_busy", tx_busy, 1);
        push(fb[17], 1'b0, w);
        chk("held_off_cycles", w, 26);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 18; i++) check_frame({3'b001, fb[i], 1'b0}, 10, 4, 1'b0, $sformatf("stream%0d", i));
        idle_check(1'b0, "stream");
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
